// File: rtl/alu_cmd_if.sv
// alu_cmd_if: host-side command/UART handshake bundle between local logic, alu_cmd_master and a uart_tx/uart_rx pair
interface alu_cmd_if #(parameter int N = 8);
   logic         i_start;
   logic [N-1:0] i_A;
   logic [N-1:0] i_B;
   logic [N-1:0] i_op;
   logic         i_tx_done;
   logic [N-1:0] i_data_rx;
   logic         i_rx_valid;
   logic [N-1:0] o_tx;
   logic         o_tx_start;
   logic [N-1:0] o_result;
   logic         o_result_valid;
   logic         o_busy;
   logic         o_timeout;
   modport master (
      input  i_start, i_A, i_B, i_op, i_tx_done, i_data_rx, i_rx_valid,
      output o_tx, o_tx_start, o_result, o_result_valid, o_busy, o_timeout
   );
   modport slave (
      output i_start, i_A, i_B, i_op, i_tx_done, i_data_rx, i_rx_valid,
      input  o_tx, o_tx_start, o_result, o_result_valid, o_busy, o_timeout
   );
endinterface

// File: rtl/alu_cmd_master.sv
// alu_cmd_master: sends A-code,A,B-code,B,OP-code,OP,R-code over UART and returns the result byte.
// Optional response timeout is enabled by defining ALU_CMD_TIMEOUT_EN.
module alu_cmd_master #(
   parameter int           N              = 8,
   parameter logic [N-1:0] A              = 'h1,
   parameter logic [N-1:0] B              = 'h2,
   parameter logic [N-1:0] OP             = 'h3,
   parameter logic [N-1:0] R              = 'h4,
   parameter int           TIMEOUT_CYCLES = 1000
) (
   input logic       clk,
   input logic       rst,
   alu_cmd_if.master bus
);
   typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, WAIT_RESULT} state_t;
   state_t       state;
   logic [2:0]   idx;
   logic [N-1:0] a_q, b_q, op_q;
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be positive");
   end
`ifdef ALU_CMD_TIMEOUT_EN
   localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CW-1:0] cnt;
`endif
   function automatic logic [N-1:0] byte_at(input logic [2:0] i);
      return i == 3'd0 ? A : i == 3'd1 ? a_q : i == 3'd2 ? B : i == 3'd3 ? b_q :
             i == 3'd4 ? OP : i == 3'd5 ? op_q : R;
   endfunction
   // Strobes default low so each assertion below lasts exactly one cycle
   always_ff @(posedge clk) begin
      bus.o_result_valid <= 1'b0;
      bus.o_timeout      <= 1'b0;
      if (rst) begin
         state          <= IDLE;
         idx            <= '0;
         a_q            <= '0;
         b_q            <= '0;
         op_q           <= '0;
         bus.o_tx       <= '0;
         bus.o_tx_start <= 1'b0;
         bus.o_result   <= '0;
         bus.o_busy     <= 1'b0;
`ifdef ALU_CMD_TIMEOUT_EN
         cnt            <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (bus.i_start) begin
               a_q            <= bus.i_A;
               b_q            <= bus.i_B;
               op_q           <= bus.i_op;
               idx            <= '0;
               bus.o_tx       <= A;
               bus.o_tx_start <= 1'b1;
               bus.o_busy     <= 1'b1;
               state          <= SEND;
            end
            SEND: begin
               bus.o_tx_start <= 1'b0;
               state          <= WAIT_DONE;
            end
            WAIT_DONE: if (bus.i_tx_done) begin
               if (idx != 3'd6) begin
                  idx            <= idx + 3'd1;
                  bus.o_tx       <= byte_at(idx + 3'd1);
                  bus.o_tx_start <= 1'b1;
                  state          <= SEND;
               end else begin
                  state <= WAIT_RESULT;
`ifdef ALU_CMD_TIMEOUT_EN
                  cnt   <= '0;
`endif
               end
            end
            WAIT_RESULT: if (bus.i_rx_valid) begin
               bus.o_result       <= bus.i_data_rx;
               bus.o_result_valid <= 1'b1;
               bus.o_busy         <= 1'b0;
               state              <= IDLE;
            end
`ifdef ALU_CMD_TIMEOUT_EN
            else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               bus.o_timeout <= 1'b1;
               bus.o_busy    <= 1'b0;
               state         <= IDLE;
            end else cnt <= cnt + CW'(1);
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule
